mu_conv: RTL and testbench



---
 rtl/mu_conv.sv | 96 +++++++++
 tb/tb_mu_conv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mu_conv.sv
// mu_conv: multiply-accumulate of one kernel_size x kernel_size window, plus bias, then round and saturate to WIDTH.
// Latency: the result is registered and appears, with a 1-cycle valid pulse, one cycle after the last pair is accepted.
// Backpressure: none, the block is always ready; a pair counts only when weight_valid && data_valid.
module mu_conv #(
  parameter int WIDTH        = 8,
  parameter int kernel_size  = 3,
  parameter int SIGN         = 1,
  parameter int FP_POSITIONS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             weight_valid,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] weight,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] bias,
  output logic [WIDTH-1:0] conv_result,
  output logic             conv_result_valid
);

  localparam int KK = kernel_size * kernel_size;
  localparam int CW = (KK > 1) ? $clog2(KK) : 1;
  // The accumulator has one spare bit above the worst-case window sum, so
  // neither the sum nor the bias add can wrap.
  localparam int AW = 2 * WIDTH + $clog2(KK) + 1;
  localparam logic SX = (SIGN != 0);

  // Clamp bounds on the rescaled sum, in accumulator width.
  localparam logic signed [AW-1:0] HI = SX ? AW'((1 << (WIDTH - 1)) - 1)
                                           : AW'((1 << WIDTH) - 1);
  localparam logic signed [AW-1:0] LO = SX ? AW'(-(1 << (WIDTH - 1)))
                                           : AW'(0);

  logic signed [AW-1:0] acc;
  logic        [CW-1:0] count;

  logic signed [AW-1:0] w_ext;
  logic signed [AW-1:0] d_ext;
  logic signed [AW-1:0] b_ext;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic    [WIDTH-1:0] sat;
  logic                accept;
  logic                last;

  assign accept = weight_valid && data_valid;
  assign last   = (count == CW'(KK - 1));

  // Extend the operands to accumulator width, sign- or zero-filled depending on
  // SIGN, and then use one signed multiply for both modes. The true product
  // always fits in AW bits.
  always_comb begin
    w_ext   = {{(AW - WIDTH){SX & weight[WIDTH-1]}}, weight};
    d_ext   = {{(AW - WIDTH){SX & data[WIDTH-1]}}, data};
    b_ext   = {{(AW - WIDTH){SX & bias[WIDTH-1]}}, bias};
    prod    = w_ext * d_ext;
    // The bias has FP fractional bits and the products have 2*FP, so the bias
    // is aligned before the add.
    sum     = acc + prod + (b_ext <<< FP_POSITIONS);
    // The arithmetic shift drops FP fractional bits and truncates toward -inf.
    shifted = sum >>> FP_POSITIONS;
    if (shifted > HI) begin
      sat = HI[WIDTH-1:0];
    end else if (shifted < LO) begin
      sat = LO[WIDTH-1:0];
    end else begin
      sat = shifted[WIDTH-1:0];
    end
  end

  // Accumulate accepted pairs and close the window on the last one. The valid
  // pulse lasts one cycle, and the result holds until the next window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc               <= '0;
      count             <= '0;
      conv_result       <= '0;
      conv_result_valid <= 1'b0;
    end else begin
      conv_result_valid <= 1'b0;
      if (accept) begin
        if (last) begin
          conv_result       <= sat;
          conv_result_valid <= 1'b1;
          acc               <= '0;
          count             <= '0;
        end else begin
          acc   <= acc + prod;
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mu_conv.sv
// Directed bench for mu_conv at its defaults (WIDTH=8, 3x3, signed, Q4.4).
// Inputs are driven on the falling edge and outputs are sampled there, half a cycle after the active edge.
module tb_mu_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic       weight_valid;
  logic       data_valid;
  logic [7:0] weight;
  logic [7:0] data;
  logic [7:0] bias;
  logic [7:0] conv_result;
  logic       conv_result_valid;

  int tests  = 0;
  int failed = 0;

  mu_conv #(
    .WIDTH(8), .kernel_size(3), .SIGN(1), .FP_POSITIONS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .weight_valid(weight_valid), .data_valid(data_valid),
    .weight(weight), .data(data), .bias(bias),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge.
  task automatic step(input logic wv, input logic dv, input logic [7:0] w, input logic [7:0] d);
    @(negedge clk);
    weight_valid = wv;
    data_valid   = dv;
    weight       = w;
    data         = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Run one window with a single weight/data pair. The next idle cycle shows the pulse.
  task automatic uniform_window(input logic [7:0] w, input logic [7:0] d, input string tag);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, w, d);
      chk({tag, "_novld"}, 32'(conv_result_valid), 32'd0);
    end
  endtask

  task automatic ramp_window(input string tag);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 8'(i + 1), 8'(i + 2));
      chk({tag, "_novld"}, 32'(conv_result_valid), 32'd0);
    end
  endtask

  int pulses;
  int first_at;
  int second_at;
  logic [7:0] last_res;

  initial begin
    rst = 1'b1;
    weight_valid = 1'b0;
    data_valid   = 1'b0;
    weight = 8'h00;
    data   = 8'h00;
    bias   = 8'h10;

    // 1. Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_res", 32'(conv_result), 32'h00);
    chk("rst_vld", 32'(conv_result_valid), 32'd0);
    rst = 1'b0;
    idle();
    chk("post_rst_vld", 32'(conv_result_valid), 32'd0);

    // 2. Uniform window: 9*6=54, plus 0x10<<4=256, gives 310; 310>>4=19=0x13
    uniform_window(8'h02, 8'h03, "uni");
    idle();
    chk("uni_vld", 32'(conv_result_valid), 32'd1);
    chk("uni_res", 32'(conv_result), 32'h13);
    idle();
    chk("uni_pulse_end", 32'(conv_result_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("uni_quiet", 32'(conv_result_valid), 32'd0);
    end
    chk("uni_hold", 32'(conv_result), 32'h13);

    // 3. Ramp window: sum (i+1)(i+2) = 330; (330+256)>>4 = 36 = 0x24
    ramp_window("ramp");
    idle();
    chk("ramp_vld", 32'(conv_result_valid), 32'd1);
    chk("ramp_res", 32'(conv_result), 32'h24);

    // 4. A reset in mid-window discards the partial sum
    step(1'b1, 1'b1, 8'h04, 8'h05);
    step(1'b1, 1'b1, 8'h04, 8'h05);
    @(negedge clk);
    weight_valid = 1'b0;
    data_valid   = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_res", 32'(conv_result), 32'h00);
    chk("midrst_vld", 32'(conv_result_valid), 32'd0);
    rst = 1'b0;
    ramp_window("ramp2");
    idle();
    chk("ramp2_vld", 32'(conv_result_valid), 32'd1);
    chk("ramp2_res", 32'(conv_result), 32'h24);

    // 5a. Positive saturation: 9*127*127 + 256 = 145417, then >>4 = 9088, clamped to 0x7F
    uniform_window(8'h7F, 8'h7F, "satp");
    idle();
    chk("satp_vld", 32'(conv_result_valid), 32'd1);
    chk("satp_res", 32'(conv_result), 32'h7F);

    // 5b. Exactly -8.0: 9*(-16*16) + 256 = -2048, then >>4 = -128 = 0x80
    uniform_window(8'hF0, 8'h10, "neg8");
    idle();
    chk("neg8_res", 32'(conv_result), 32'h80);

    // 5c. Negative saturation: 9*(-128*127) + 256 is far below -2048*16
    uniform_window(8'h80, 8'h7F, "satn");
    idle();
    chk("satn_res", 32'(conv_result), 32'h80);

    // 5d. Truncation toward -inf: 9*(-1*1) + 0 = -9, and -9>>>4 = -1 = 0xFF (not 0)
    bias = 8'h00;
    uniform_window(8'hFF, 8'h01, "trunc");
    idle();
    chk("trunc_res", 32'(conv_result), 32'hFF);
    bias = 8'h10;

    // 6a. Gating: cycles with only one valid carry large values that must not count
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b1, 1'b0, 8'h7F, 8'h7F);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b0, 1'b1, 8'h7F, 8'h7F);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b0, 1'b0, 8'h7F, 8'h7F);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b1, 1'b0, 8'h7F, 8'h7F);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b0, 1'b1, 8'h7F, 8'h7F);
    chk("gate_early_vld", 32'(conv_result_valid), 32'd0);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    step(1'b1, 1'b1, 8'h02, 8'h03);
    chk("gate_8_vld", 32'(conv_result_valid), 32'd0);
    idle();
    chk("gate_vld", 32'(conv_result_valid), 32'd1);
    chk("gate_res", 32'(conv_result), 32'h13);

    // 6b. Streaming: both valids high for 18 cycles, so two pulses 9 cycles apart
    pulses    = 0;
    first_at  = -1;
    second_at = -1;
    last_res  = 8'h00;
    for (int i = 0; i < 22; i++) begin
      if (i < 18) step(1'b1, 1'b1, 8'h02, 8'h03);
      else        idle();
      if (conv_result_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
        last_res = conv_result;
      end
    end
    chk("stream_pulses", 32'(pulses), 32'd2);
    chk("stream_first", 32'(first_at), 32'd9);
    chk("stream_gap", 32'(second_at - first_at), 32'd9);
    chk("stream_res", 32'(last_res), 32'h13);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
